ads_multi_ch_acquire: RTL

Parametrised successor to the fixed 4-channel ADS word demultiplexer. Takes 16-bit-class words from the ADS SPI receive engine, using the rising edge of the ADS chip-select as the word-complete strobe and the engine's packet counter for frame alignment. Routes each data word to its channel, maintains per-channel holding registers and reports frame completion and framing errors to downstream filtering and telemetry logic.

---
 rtl/ads_acq_pkg.sv | 21 ++
 rtl/ads_multi_ch_acquire_if.sv | 44 ++++
 rtl/ads_cs_edge_sync.sv | 24 ++
 rtl/ads_multi_ch_acquire.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ads_acq_pkg.sv
// Shared types and constants for the multi-channel ADS acquisition block.
// ADS_ALARM_EN (when defined) adds the three alarm trailer words to each frame.
package ads_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_ALM,
        ST_DONE
    } acq_state_e;

    localparam int ALARM_WORDS       = 3;
    localparam int PKG_FIRST_DEFAULT = 4;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ads_multi_ch_acquire_if.sv
// Bundle between the SPI receive engine side and the acquisition block.
// Alarm outputs exist only when ADS_ALARM_EN is defined.
interface ads_multi_ch_acquire_if #(
    parameter int CH_NUM = 4,
    parameter int DW     = 16
) ();
    localparam int CW = ads_acq_pkg::ch_width(CH_NUM);

    logic                 ads_cs;
    logic [15:0]          pkg_num;
    logic [DW-1:0]        receive_data;
    logic [CH_NUM*DW-1:0] ch_data;
    logic [DW-1:0]        data_out;
    logic [CW-1:0]        data_ch;
    logic                 data_valid;
    logic                 frame_done;
    logic [15:0]          frame_cnt;
    logic [7:0]           extra_cnt;
    logic                 aligned;
`ifdef ADS_ALARM_EN
    logic [7:0]           alarm_overview;
    logic [7:0]           alarm_ch_t;
    logic [7:0]           alarm_ch_a;
`endif

    modport master (
        output ads_cs, pkg_num, receive_data,
        input  ch_data, data_out, data_ch, data_valid, frame_done,
               frame_cnt, extra_cnt, aligned
`ifdef ADS_ALARM_EN
        , input alarm_overview, alarm_ch_t, alarm_ch_a
`endif
    );

    modport slave (
        input  ads_cs, pkg_num, receive_data,
        output ch_data, data_out, data_ch, data_valid, frame_done,
               frame_cnt, extra_cnt, aligned
`ifdef ADS_ALARM_EN
        , output alarm_overview, alarm_ch_t, alarm_ch_a
`endif
    );

endinterface

// File: rtl/ads_cs_edge_sync.sv
// Two-flop synchroniser for the ADS chip-select plus rising-edge detector.
module ads_cs_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ads_cs_i,
    output logic we_o
);
    logic meta_q, sync_q, hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= ads_cs_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign we_o = sync_q & ~hist_q;

endmodule

// File: rtl/ads_multi_ch_acquire.sv
// Demultiplexes ADS words into CH_NUM channel registers with frame tracking.
// Optional alarm trailer words are enabled with ADS_ALARM_EN.
module ads_multi_ch_acquire
    import ads_acq_pkg::*;
#(
    parameter int CH_NUM    = 4,
    parameter int DW        = 16,
    parameter int PKG_FIRST = PKG_FIRST_DEFAULT
) (
    input logic clk,
    input logic rst,
    ads_multi_ch_acquire_if.slave bus
);
    localparam int CW = ch_width(CH_NUM);

    logic          we;
    logic          hdr_word, data_word, last_ch;
    logic          ch_load, frame_end, extra_inc;
    acq_state_e    state_q, state_d;
    logic [CW-1:0] idx_q;
    logic [DW-1:0] data_out_q;
    logic [CW-1:0] data_ch_q;
    logic          data_valid_q, frame_done_q, aligned_q;
    logic [15:0]   frame_cnt_q;
    logic [7:0]    extra_cnt_q;
    wire  [CH_NUM*DW-1:0] ch_flat;

    ads_cs_edge_sync u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .ads_cs_i (bus.ads_cs),
        .we_o     (we)
    );

    assign hdr_word  = we && (bus.pkg_num < 16'(PKG_FIRST));
    assign data_word = we && !hdr_word;
    assign last_ch   = (idx_q == CW'(CH_NUM - 1));

`ifdef ADS_ALARM_EN
    logic       alm_load, alm_last;
    logic [1:0] alm_idx_q;
    logic [7:0] alarm_overview_q, alarm_ch_t_q, alarm_ch_a_q;
    assign alm_last = (alm_idx_q == 2'(ALARM_WORDS - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (hdr_word) begin
            state_d = ST_HDR;
        end else if (data_word) begin
            case (state_q)
                ST_HDR, ST_DATA: begin
                    state_d = ST_DATA;
`ifdef ADS_ALARM_EN
                    if (last_ch) state_d = ST_ALM;
`else
                    if (last_ch) state_d = ST_DONE;
`endif
                end
`ifdef ADS_ALARM_EN
                ST_ALM: if (alm_last) state_d = ST_DONE;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        ch_load   = data_word && (state_q == ST_HDR || state_q == ST_DATA);
        extra_inc = data_word && (state_q == ST_DONE);
`ifdef ADS_ALARM_EN
        alm_load  = data_word && (state_q == ST_ALM);
        frame_end = alm_load && alm_last;
`else
        frame_end = ch_load && last_ch;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            data_out_q   <= '0;
            data_ch_q    <= '0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            aligned_q    <= 1'b0;
            frame_cnt_q  <= '0;
            extra_cnt_q  <= '0;
        end else begin
            data_valid_q <= ch_load;
            frame_done_q <= frame_end;
            if (hdr_word) begin
                idx_q     <= '0;
                aligned_q <= 1'b1;
            end else if (ch_load) begin
                data_out_q <= bus.receive_data;
                data_ch_q  <= idx_q;
                idx_q      <= last_ch ? '0 : idx_q + 1'b1;
            end
            if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (extra_inc && extra_cnt_q != 8'hFF) extra_cnt_q <= extra_cnt_q + 8'd1;
        end
    end

`ifdef ADS_ALARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alm_idx_q        <= '0;
            alarm_overview_q <= '0;
            alarm_ch_t_q     <= '0;
            alarm_ch_a_q     <= '0;
        end else if (ch_load && last_ch) begin
            alm_idx_q <= '0;
        end else if (alm_load) begin
            alm_idx_q <= alm_idx_q + 2'd1;
            case (alm_idx_q)
                2'd0:    alarm_overview_q <= bus.receive_data[DW-1 -: 8];
                2'd1:    alarm_ch_t_q     <= bus.receive_data[DW-1 -: 8];
                default: alarm_ch_a_q     <= bus.receive_data[DW-1 -: 8];
            endcase
        end
    end

    assign bus.alarm_overview = alarm_overview_q;
    assign bus.alarm_ch_t     = alarm_ch_t_q;
    assign bus.alarm_ch_a     = alarm_ch_a_q;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [DW-1:0] ch_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                                 ch_q <= '0;
                else if (ch_load && idx_q == CW'(gi))    ch_q <= bus.receive_data;
            end
            assign ch_flat[gi*DW +: DW] = ch_q;
        end
    endgenerate

    assign bus.ch_data    = ch_flat;
    assign bus.data_out   = data_out_q;
    assign bus.data_ch    = data_ch_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.extra_cnt  = extra_cnt_q;
    assign bus.aligned    = aligned_q;

endmodule
